// File: rtl/sd_pkg.sv
// Shared SD CMD-line definitions: response encodings, frame geometry, CRC7 polynomial, receiver states.
package sd_pkg;

  localparam logic [2:0] RESP_NONE = 3'd0;
  localparam logic [2:0] RESP_R1   = 3'd1;
  localparam logic [2:0] RESP_R1B  = 3'd2;
  localparam logic [2:0] RESP_R2   = 3'd3;
  localparam logic [2:0] RESP_R3   = 3'd4;
  localparam logic [2:0] RESP_R6   = 3'd6;
  localparam logic [2:0] RESP_R7   = 3'd7;

  localparam int unsigned FRAME_LEN_SHORT = 48;
  localparam int unsigned FRAME_LEN_R2    = 136;

  localparam logic [5:0] IDX_FIXED = 6'h3F;

  // x^7 + x^3 + 1, the x^7 term is implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_RECV,
    ST_CHECK
  } state_t;

  function automatic logic resp_valid(input logic [2:0] t);
    return (t == RESP_R1) || (t == RESP_R1B) || (t == RESP_R2) ||
           (t == RESP_R3) || (t == RESP_R6) || (t == RESP_R7);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), MSB-first; shared by the CMD transmitter and receiver.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_bit,
  output logic [6:0] crc
);

  logic fb;

  assign fb = data_bit ^ crc[6];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= 7'd0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end
  end

endmodule

// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver: hunts the start bit, shifts in a 48/136-bit frame, checks and decodes it.
// Define SD_RESP_CRC_CHECK_EN to compute and check the received CRC7.
module sd_cmd_response_rx
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_in,
  input  logic         arm,
  input  logic [2:0]   resp_type,
  input  logic [5:0]   exp_index,
  input  logic         r2_is_csd,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic         index_err,
  output logic         end_err,
  output logic         cid_en,
  output logic         csd_en,
  output logic         ocr_en,
  output logic         rca_en,
  output logic         stat_en,
  output logic [127:0] cid_data,
  output logic [127:0] csd_data,
  output logic [31:0]  ocr_data,
  output logic [15:0]  rca_data,
  output logic [63:0]  stat_data
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [135:0]     sr_q;
  logic [2:0]       type_q;
  logic [5:0]       idx_q;
  logic             csd_q;

  logic             arm_ok, arm_none, shift, tmo_hit, is_long;
  logic [CNT_W-1:0] last_pos;

  assign is_long  = (type_q == RESP_R2);
  assign last_pos = is_long ? CNT_W'(FRAME_LEN_R2 - 1) : CNT_W'(FRAME_LEN_SHORT - 1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; cnt_q is the timeout count in HUNT and the frame bit index in RECV
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arm_ok   = 1'b0;
    arm_none = 1'b0;
    shift    = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          if (resp_valid(resp_type)) begin
            arm_ok  = 1'b1;
            cnt_d   = '0;
            state_d = ST_HUNT;
          end else begin
            arm_none = 1'b1;
          end
        end
      end
      ST_HUNT: begin
        if (!cmd_in) begin
          shift   = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = ST_RECV;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RECV: begin
        shift = 1'b1;
        if (cnt_q == last_pos) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Frame shift register and request parameters latched at arm
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      type_q <= RESP_NONE;
      idx_q  <= '0;
      csd_q  <= 1'b0;
    end else begin
      if (shift) begin
        sr_q <= {sr_q[134:0], cmd_in};
      end
      if (arm_ok) begin
        type_q <= resp_type;
        idx_q  <= exp_index;
        csd_q  <= r2_is_csd;
      end
    end
  end

  logic        start_bit, trans_bit, end_bit;
  logic [5:0]  rx_index;
  logic [31:0] arg;
  logic        end_bad, idx_bad, crc_bad, frame_ok;

  assign start_bit = is_long ? sr_q[135] : sr_q[47];
  assign trans_bit = is_long ? sr_q[134] : sr_q[46];
  assign rx_index  = is_long ? sr_q[133:128] : sr_q[45:40];
  assign arg       = sr_q[39:8];
  assign end_bit   = sr_q[0];

`ifdef SD_RESP_CRC_CHECK_EN
  logic             crc_en;
  logic [CNT_W-1:0] pos;
  logic [6:0]       crc_val;
  logic [6:0]       rx_crc;

  // 48-bit frames cover bits 0..39; R2 covers only the 120 register bits 8..127
  assign pos    = (state_q == ST_HUNT) ? '0 : cnt_q;
  assign crc_en = shift && (is_long ? ((pos >= CNT_W'(8)) && (pos <= CNT_W'(127)))
                                    : (pos <= CNT_W'(39)));
  assign rx_crc = sr_q[7:1];

  sd_crc7 u_crc7 (
    .clk      (clk),
    .reset    (reset),
    .clear    (arm_ok),
    .enable   (crc_en),
    .data_bit (cmd_in),
    .crc      (crc_val)
  );

  assign crc_bad = (type_q != RESP_R3) && (rx_crc != crc_val);
`else
  assign crc_bad = 1'b0;
`endif

  assign end_bad  = !end_bit || trans_bit || start_bit;
  assign idx_bad  = (is_long || (type_q == RESP_R3)) ? (rx_index != IDX_FIXED)
                                                     : (rx_index != idx_q);
  assign frame_ok = !(end_bad || idx_bad || crc_bad);

  // Registered status, enables and register-file data
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      crc_err     <= 1'b0;
      index_err   <= 1'b0;
      end_err     <= 1'b0;
      cid_en      <= 1'b0;
      csd_en      <= 1'b0;
      ocr_en      <= 1'b0;
      rca_en      <= 1'b0;
      stat_en     <= 1'b0;
      cid_data    <= '0;
      csd_data    <= '0;
      ocr_data    <= '0;
      rca_data    <= '0;
      stat_data   <= '0;
    end else begin
      done    <= 1'b0;
      cid_en  <= 1'b0;
      csd_en  <= 1'b0;
      ocr_en  <= 1'b0;
      rca_en  <= 1'b0;
      stat_en <= 1'b0;
      if (arm_ok || arm_none) begin
        timeout_err <= 1'b0;
        crc_err     <= 1'b0;
        index_err   <= 1'b0;
        end_err     <= 1'b0;
      end
      if (arm_ok) begin
        busy <= 1'b1;
      end
      if (arm_none) begin
        done <= 1'b1;
      end
      if (tmo_hit) begin
        done        <= 1'b1;
        busy        <= 1'b0;
        timeout_err <= 1'b1;
      end
      if (state_q == ST_CHECK) begin
        done      <= 1'b1;
        busy      <= 1'b0;
        end_err   <= end_bad;
        index_err <= idx_bad;
        crc_err   <= crc_bad;
        if (frame_ok) begin
          case (type_q)
            RESP_R1, RESP_R1B, RESP_R7: begin
              stat_en   <= 1'b1;
              stat_data <= {26'd0, rx_index, arg};
            end
            RESP_R2: begin
              if (csd_q) begin
                csd_en   <= 1'b1;
                csd_data <= {sr_q[127:1], 1'b1};
              end else begin
                cid_en   <= 1'b1;
                cid_data <= {sr_q[127:1], 1'b1};
              end
            end
            RESP_R3: begin
              ocr_en    <= 1'b1;
              ocr_data  <= arg;
              stat_en   <= 1'b1;
              stat_data <= {26'd0, IDX_FIXED, 32'd0};
            end
            RESP_R6: begin
              rca_en    <= 1'b1;
              rca_data  <= arg[31:16];
              stat_en   <= 1'b1;
              stat_data <= {26'd0, rx_index, 16'd0, arg[15:0]};
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_response_rx.sv
// Scoreboard bench for sd_cmd_response_rx: expectations queued at arm, checked on every done pulse.
module tb_sd_cmd_response_rx;

  logic         clk, reset, cmd_in, arm, r2_is_csd;
  logic [2:0]   resp_type;
  logic [5:0]   exp_index;
  logic         busy, done, timeout_err, crc_err, index_err, end_err;
  logic         cid_en, csd_en, ocr_en, rca_en, stat_en;
  logic [127:0] cid_data, csd_data;
  logic [31:0]  ocr_data;
  logic [15:0]  rca_data;
  logic [63:0]  stat_data;

  sd_cmd_response_rx #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .arm(arm), .resp_type(resp_type),
    .exp_index(exp_index), .r2_is_csd(r2_is_csd), .busy(busy), .done(done),
    .timeout_err(timeout_err), .crc_err(crc_err), .index_err(index_err), .end_err(end_err),
    .cid_en(cid_en), .csd_en(csd_en), .ocr_en(ocr_en), .rca_en(rca_en), .stat_en(stat_en),
    .cid_data(cid_data), .csd_data(csd_data), .ocr_data(ocr_data), .rca_data(rca_data),
    .stat_data(stat_data)
  );

  typedef struct {
    string        name;
    int           arm_cyc;
    int           lat;
    logic         tmo, crc, idx, endf;
    logic [4:0]   en;    // {cid, csd, ocr, rca, stat}
    logic [127:0] cid, csd;
    logic [31:0]  ocr;
    logic [15:0]  rca;
    logic [63:0]  stat;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [119:0] bits, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] mk48(input logic trans, input logic [5:0] idx,
                                       input logic [31:0] a, input logic endb);
    logic [39:0] hdr;
    hdr = {1'b0, trans, idx, a};
    return {hdr, crc7({80'd0, hdr}, 40), endb};
  endfunction

  function automatic exp_t blank(input string n, input int lat);
    exp_t e;
    e.name = n; e.arm_cyc = 0; e.lat = lat;
    e.tmo = 1'b0; e.crc = 1'b0; e.idx = 1'b0; e.endf = 1'b0; e.en = 5'd0;
    e.cid = '0; e.csd = '0; e.ocr = '0; e.rca = '0; e.stat = '0;
    return e;
  endfunction

  // Scoreboard monitor: compares every done pulse against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq({e.name, "/lat"}, cyc - e.arm_cyc, e.lat);
        check_eq({e.name, "/flags"}, {timeout_err, crc_err, index_err, end_err},
                 {e.tmo, e.crc, e.idx, e.endf});
        check_eq({e.name, "/en"}, {cid_en, csd_en, ocr_en, rca_en, stat_en}, e.en);
        if (e.en[4]) check_eq({e.name, "/cid"}, cid_data, e.cid);
        if (e.en[3]) check_eq({e.name, "/csd"}, csd_data, e.csd);
        if (e.en[2]) check_eq({e.name, "/ocr"}, ocr_data, e.ocr);
        if (e.en[1]) check_eq({e.name, "/rca"}, rca_data, e.rca);
        if (e.en[0]) check_eq({e.name, "/stat"}, stat_data, e.stat);
        check_eq({e.name, "/busy_at_done"}, busy, 0);
      end
    end else if ({cid_en, csd_en, ocr_en, rca_en, stat_en} !== 5'd0 && reset === 1'b0) begin
      check_eq("en_without_done", {cid_en, csd_en, ocr_en, rca_en, stat_en}, 0);
    end
  end

  // Called at a negedge: arm, hunt idle bits, then frame bits MSB-first
  task automatic run_frame(input exp_t e, input logic push, input logic [2:0] t,
                           input logic [5:0] ei, input logic csd, input logic [135:0] f,
                           input int len, input int hunt, input int busy_arm_at,
                           input int abort_at);
    arm = 1'b1; resp_type = t; exp_index = ei; r2_is_csd = csd; cmd_in = 1'b1;
    e.arm_cyc = cyc + 1;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    arm = 1'b0; resp_type = 3'd0; exp_index = 6'd0; r2_is_csd = 1'b0;
    for (int h = 0; h < hunt; h++) begin
      cmd_in = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < len; i++) begin
      cmd_in = f[len - 1 - i];
      if (i == busy_arm_at) begin
        arm = 1'b1; resp_type = 3'd4; exp_index = 6'd5;
      end
      if (i == abort_at) reset = 1'b1;
      @(negedge clk);
      arm = 1'b0; resp_type = 3'd0; exp_index = 6'd0;
      if (i == busy_arm_at) check_eq({e.name, "/busy_mid"}, busy, 1);
      if (i == abort_at) begin
        reset = 1'b0;
        cmd_in = 1'b1;
        check_eq("busy_after_reset", busy, 0);
        break;
      end
    end
    cmd_in = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 30 && sb_q.size() != 0; k++) @(negedge clk);
    check_eq({tag, "/drained"}, sb_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t         e;
    logic [47:0]  f48;
    logic [135:0] f;
    logic [119:0] pl;
    logic [6:0]   pc;

    reset = 1'b1; cmd_in = 1'b1; arm = 1'b0; resp_type = 3'd0; exp_index = 6'd0;
    r2_is_csd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset/status", {busy, done, timeout_err, crc_err, index_err, end_err}, 0);
    check_eq("reset/en", {cid_en, csd_en, ocr_en, rca_en, stat_en}, 0);
    check_eq("reset/data", cid_data | csd_data | {96'd0, ocr_data} | {112'd0, rca_data}
             | {64'd0, stat_data}, 0);

    // R7 for CMD8, with an arm pulse while busy that must be ignored
    e = blank("r7_ok", 3 + 48 + 1);
    e.en = 5'b00001; e.stat = 64'h0000_0008_0000_01AA;
    f48 = 48'h08_00_00_01_AA_13;
    run_frame(e, 1'b1, 3'd7, 6'd8, 1'b0, {88'd0, f48}, 48, 3, 20, -1);
    drain("r7_ok");

    // Same frame, corrupted CRC byte
    e = blank("r7_badcrc", 0 + 48 + 1);
`ifdef SD_RESP_CRC_CHECK_EN
    e.crc = 1'b1;
`else
    e.en = 5'b00001; e.stat = 64'h0000_0008_0000_01AA;
`endif
    f48 = 48'h08_00_00_01_AA_15;
    run_frame(e, 1'b1, 3'd7, 6'd8, 1'b0, {88'd0, f48}, 48, 0, -1, -1);
    drain("r7_badcrc");

    // R3: CRC field all ones, never a CRC error
    e = blank("r3", 5 + 48 + 1);
    e.en = 5'b00101; e.ocr = 32'h80FF_8000; e.stat = 64'h0000_003F_0000_0000;
    f48 = 48'h3F_80_FF_80_00_FF;
    run_frame(e, 1'b1, 3'd4, 6'd0, 1'b0, {88'd0, f48}, 48, 5, -1, -1);
    drain("r3");

    // R6 for CMD3
    e = blank("r6", 1 + 48 + 1);
    e.en = 5'b00011; e.rca = 16'hAAAA; e.stat = 64'h0000_0003_0000_0500;
    f48 = mk48(1'b0, 6'd3, 32'hAAAA_0500, 1'b1);
    run_frame(e, 1'b1, 3'd6, 6'd3, 1'b0, {88'd0, f48}, 48, 1, -1, -1);
    drain("r6");

    // No-response type: done in the cycle right after arm
    e = blank("no_resp", 0);
    run_frame(e, 1'b1, 3'd5, 6'd0, 1'b0, '0, 0, 0, -1, -1);
    drain("no_resp");

    // Timeout with CMD held high
    e = blank("timeout", 64);
    e.tmo = 1'b1;
    run_frame(e, 1'b1, 3'd1, 6'd17, 1'b0, '0, 0, 70, -1, -1);
    drain("timeout");

    // R1 index mismatch
    e = blank("r1_badidx", 2 + 48 + 1);
    e.idx = 1'b1;
    f48 = mk48(1'b0, 6'd16, 32'h0000_0900, 1'b1);
    run_frame(e, 1'b1, 3'd1, 6'd17, 1'b0, {88'd0, f48}, 48, 2, -1, -1);
    drain("r1_badidx");

    // R1 end bit 0
    e = blank("r1_badend", 0 + 48 + 1);
    e.endf = 1'b1;
    f48 = mk48(1'b0, 6'd13, 32'h0000_0900, 1'b0);
    run_frame(e, 1'b1, 3'd1, 6'd13, 1'b0, {88'd0, f48}, 48, 0, -1, -1);
    drain("r1_badend");

    // R1 transmission bit 1
    e = blank("r1_badtx", 0 + 48 + 1);
    e.endf = 1'b1;
    f48 = mk48(1'b1, 6'd13, 32'h0000_0900, 1'b1);
    run_frame(e, 1'b1, 3'd1, 6'd13, 1'b0, {88'd0, f48}, 48, 0, -1, -1);
    drain("r1_badtx");

    // R1b good
    e = blank("r1b_ok", 4 + 48 + 1);
    e.en = 5'b00001; e.stat = 64'h0000_0007_0000_0800;
    f48 = mk48(1'b0, 6'd7, 32'h0000_0800, 1'b1);
    run_frame(e, 1'b1, 3'd2, 6'd7, 1'b0, {88'd0, f48}, 48, 4, -1, -1);
    drain("r1b_ok");

    // R2 into CSD
    pl = 120'h0123456789ABCDEF_FEDCBA98765432;
    pc = crc7(pl, 120);
    f  = {2'b00, 6'h3F, pl, pc, 1'b1};
    e  = blank("r2_csd", 2 + 136 + 1);
    e.en = 5'b01000; e.csd = {pl, pc, 1'b1};
    run_frame(e, 1'b1, 3'd3, 6'd0, 1'b1, f, 136, 2, 100, -1);
    drain("r2_csd");

    // R2 into CID
    pl = 120'hF0E1D2C3B4A59687_78695A4B3C2D1E;
    pc = crc7(pl, 120);
    f  = {2'b00, 6'h3F, pl, pc, 1'b1};
    e  = blank("r2_cid", 0 + 136 + 1);
    e.en = 5'b10000; e.cid = {pl, pc, 1'b1};
    run_frame(e, 1'b1, 3'd3, 6'd0, 1'b0, f, 136, 0, -1, -1);
    drain("r2_cid");

    // Second R2 frame aborted by reset at bit 60: no done may follow
    e = blank("r2_abort", 0);
    run_frame(e, 1'b0, 3'd3, 6'd0, 1'b1, f, 136, 1, -1, 60);
    repeat (150) @(negedge clk);
    check_eq("abort/busy_idle", busy, 0);

    // Receiver still usable after the abort
    e = blank("r7_after_reset", 0 + 48 + 1);
    e.en = 5'b00001; e.stat = 64'h0000_0008_0000_01AA;
    f48 = 48'h08_00_00_01_AA_13;
    run_frame(e, 1'b1, 3'd7, 6'd8, 1'b0, {88'd0, f48}, 48, 0, -1, -1);
    drain("r7_after_reset");

    repeat (5) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_response_rx.md
Name: sd_cmd_response_rx

Overview:
- Serial receiver for SD CMD-line responses. Armed by the command sequencer after a command is sent.
- Hunts for the response start bit, then shifts in a 48-bit (R1/R1b/R3/R6/R7) or 136-bit (R2) frame.
- Validates the end bit, command index and CRC7, then decodes the payload.
- Drives data and one-cycle write enables straight into the card register file (CID, CSD, OCR, RCA, status). Sits directly upstream of that register file.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles from arm to start bit (NCR window).
- CNT_W, 8, width of the bit/timeout counter; must hold max(136, TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_in  in  1  CMD line, already synchronised, one bit per clk.
- arm  in  1  pulse: start listening for a response; ignored while busy.
- resp_type  in  3  sampled at arm: 1=R1, 2=R1b, 3=R2, 4=R3, 6=R6, 7=R7; other values = no response.
- exp_index  in  6  sampled at arm: command index expected in R1/R1b/R6/R7.
- r2_is_csd  in  1  sampled at arm: R2 payload goes to CSD (1) or CID (0).
- busy  out  1  high from accepted arm until done.
- done  out  1  one-cycle pulse ending every accepted arm.
- timeout_err, crc_err, index_err, end_err  out  1 each  status flags, valid at done, held until the next accepted arm.
- cid_en, csd_en, ocr_en, rca_en, stat_en  out  1 each  one-cycle write enables, coincident with done.
- cid_data, csd_data  out  128  R2 payload; bits[127:1] = frame bits 127..1, bit0 = 1.
- ocr_data  out  32  R3 argument.
- rca_data  out  16  R6 argument[31:16].
- stat_data  out  64  {26'b0, index[5:0], status[31:0]}.

Behaviour:
- Reset: state IDLE; all outputs 0; data outputs 0.
- States: IDLE, HUNT, RECV, CHECK.
- IDLE:
  - arm with a valid resp_type → HUNT. Latch type, index, r2 select; clear flags; counter = 0.
  - arm with "no response" type → done pulse next cycle with no enables, stay IDLE.
- HUNT:
  - cmd_in==0 → RECV; that start bit is frame bit 0.
  - Otherwise counter increments. Counter reaching TIMEOUT_CYCLES-1 without a start bit → IDLE with done and timeout_err; no enables.
- RECV:
  - Shift cmd_in MSB-first into a 136-bit shift register.
  - Collect 47 further bits (48-bit frames) or 135 further bits (R2).
  - CRC7 (x^7+x^3+1, init 0) updated serially:
    - 48-bit frames: over frame bits 0..39, i.e. start, transmission, index and argument.
    - R2: over the 120 CID/CSD bits only, skipping the first 8 bits.
  - After the last bit → CHECK.
- CHECK (exactly one cycle, then IDLE). Assert done, then evaluate:
  - end_err: last bit != 1.
  - Transmission bit != 0 also sets end_err.
  - crc_err: received CRC7 != computed CRC7. Never set for R3, whose CRC field is 7'h7F.
  - index_err: R1/R1b/R6/R7 only, received index != exp_index. R2/R3 require 6'h3F; a mismatch also sets index_err.
- Enables (only if no flag is set):
  - R1/R1b/R7: stat_en; stat_data = {26'b0, index, arg}.
  - R2: cid_en or csd_en per r2_is_csd.
  - R3: ocr_en, plus stat_en with index field 6'h3F and status 0.
  - R6: rca_en, plus stat_en with status[15:0] = arg[15:0] and upper status bits 0.
- Data outputs update only on cycles with an enable; otherwise they hold.
- R1b: busy signalling on DAT0 is outside this block; done refers to the CMD frame only.
- arm while busy: ignored; no effect on the frame in progress.
- reset mid-frame: returns to IDLE with no done and no enables.
- Latency:
  - done = 1 cycle after the last frame bit.
  - Total from arm = hunt cycles + frame length + 1.

Optional Feature:
- Macro SD_RESP_CRC_CHECK_EN.
- Defined: CRC7 computed and checked as above.
- Undefined: no CRC logic; crc_err tied 0; enables depend only on end/index checks.

Decomposition:
- Shared package sd_pkg holds:
  - resp_type encodings (RESP_NONE, RESP_R1, RESP_R1B, RESP_R2, RESP_R3, RESP_R6, RESP_R7).
  - Frame lengths 48 and 136.
  - Index 6'h3F.
  - CRC7 polynomial constant.
  - State enum.
- One sub-module: sd_crc7, a serial CRC7 with clear/enable/bit inputs and a 7-bit output, reusable by the command transmitter.

Test Plan:
- R7 for CMD8: arm with resp_type=7, exp_index=8, then bits 0x08_00_00_01_AA_13 → done, stat_en, stat_data=64'h0000_0008_0000_01AA, all flags 0.
- Same R7 frame with CRC byte 0x15 → crc_err=1, no stat_en (with SD_RESP_CRC_CHECK_EN); without the macro → stat_en, crc_err=0.
- R3 frame 0x3F_80_FF_80_00_FF → ocr_en, ocr_data=32'h80FF8000, stat_en with index 6'h3F, crc_err=0.
- R6 for CMD3, arg 0xAAAA0500 with valid CRC → rca_en, rca_data=16'hAAAA, stat_data[15:0]=16'h0500.
- arm with resp_type=1, cmd_in held 1 → timeout_err and done exactly TIMEOUT_CYCLES cycles after HUNT entry, no enables.
- R2 with r2_is_csd=1 and valid internal CRC, with reset asserted at bit 60 of a second frame:
  - First frame → csd_en, csd_data[0]=1.
  - Second frame → no done, busy=0 the cycle after reset.
